ahb_slave_mem: RTL and testbench

- AHB slave-side responder: a word-addressed register memory that completes transfers issued by the master interface.
- Serves the bus as a selectable slave, with a configurable number of wait states.
- Returns OKAY for in-range accesses and a two-cycle ERROR for out-of-range addresses.
- Completes the loop opposite the master stimulus and interface: writes land in storage, reads return stored data.

---
 rtl/ahb_pkg.sv | 35 +++
 rtl/ahb_slave_regfile.sv | 55 +++++
 rtl/ahb_slave_mem.sv | 128 ++++++++++++
 tb/tb_ahb_slave_mem.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB constants and the slave state type.
//   HTRANS_* : transfer type encodings (IDLE, BUSY, NONSEQ, SEQ)
//   HRESP_*  : response encodings (OKAY, ERROR)
//   slave_state_e : data-phase state of the memory slave
//   is_active()   : true for transfer types that start an access
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    // NONSEQ and SEQ carry an access; IDLE and BUSY are bus filler.
    function automatic logic is_active(input logic [1:0] trans);
        logic act;
        act = 1'b0;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
        endcase
        return act;
    endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// ahb_slave_regfile: DEPTH x 32 storage behind the AHB memory slave.
//   hclk, hresetn : clock, asynchronous active-low clear of every word
//   we, waddr, wdata : write port, applied at the rising edge
//   re, raddr        : read request, captured at the rising edge
//   rdata            : registered read data, held until the next read
// A read and a write to the same index on one edge returns the new data.
module ahb_slave_regfile
    import ahb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic             re,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
        end
    end

    // NOTE: the array is reset because the bus contract promises all-zero
    // contents after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB slave answering from a word-indexed register memory.
//   hclk, hresetn : bus clock, asynchronous active-low reset
//   hsel, haddr, hwrite, htrans, hready : address phase from the master
//   hwdata    : write data in the data phase
//   hreadyout : low while wait states or the first error cycle run
//   hrdata    : registered read data
//   hresp     : OKAY, or ERROR for two cycles on an out-of-range index
module ahb_slave_mem
    import ahb_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic        hreadyout,
    output logic [31:0] hrdata,
    output logic        hresp
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = 3;

    slave_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic             write_q, write_d;

    logic accept;
    logic range_ok;
    logic mem_we;
    logic rd_en;

    assign range_ok = (haddr < 32'(DEPTH));

    // NOTE: every signal driven here gets a default before the case so the
    // block stays purely combinational (no latch on an unassigned path).
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                mem_we  = write_q;
                state_d = ST_IDLE;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp   = HRESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A new address phase is only taken on a cycle this slave is ready,
        // which also lets DATA and ERR2 pipeline straight into the next one.
        accept = hsel && hready && hreadyout && is_active(htrans);
        rd_en  = accept && !hwrite && range_ok;

        if (accept) begin
            addr_d  = haddr[IDX_W-1:0];
            write_d = hwrite;
            if (!range_ok) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(WAIT_STATES);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
        end
    end

    ahb_slave_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .hclk    (hclk),
        .hresetn (hresetn),
        .we      (mem_we),
        .waddr   (addr_q),
        .wdata   (hwdata),
        .re      (rd_en),
        .raddr   (haddr[IDX_W-1:0]),
        .rdata   (hrdata)
    );

endmodule

// File: tb/tb_ahb_slave_mem.sv
module tb_ahb_slave_mem;
    import ahb_pkg::*;

    localparam int DEPTH = 16;
    localparam int NDUT  = 2;   // index 0: WAIT_STATES=1, index 1: WAIT_STATES=0

    typedef struct {
        int          dut;
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic        chk_rd;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel_v     [NDUT];
    logic [31:0] haddr_v    [NDUT];
    logic        hwrite_v   [NDUT];
    logic [1:0]  htrans_v   [NDUT];
    logic [31:0] hwdata_v   [NDUT];
    logic        block_v    [NDUT];
    logic        hready_v   [NDUT];
    logic        hreadyout_v[NDUT];
    logic [31:0] hrdata_v   [NDUT];
    logic        hresp_v    [NDUT];

    int checks = 0;
    int errors = 0;

    logic [31:0] model_mem [NDUT][DEPTH];
    vec_t        tbl[$];
    vec_t        xq[$];

    always #5 hclk = ~hclk;

    // Single-slave bus: hready follows the slave unless the bench holds it low.
    assign hready_v[0] = hreadyout_v[0] & ~block_v[0];
    assign hready_v[1] = hreadyout_v[1] & ~block_v[1];

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(1)) dut_ws1 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[0]), .haddr(haddr_v[0]),
        .hwrite(hwrite_v[0]), .htrans(htrans_v[0]), .hwdata(hwdata_v[0]),
        .hready(hready_v[0]), .hreadyout(hreadyout_v[0]), .hrdata(hrdata_v[0]),
        .hresp(hresp_v[0])
    );

    ahb_slave_mem #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_ws0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel_v[1]), .haddr(haddr_v[1]),
        .hwrite(hwrite_v[1]), .htrans(htrans_v[1]), .hwdata(hwdata_v[1]),
        .hready(hready_v[1]), .hreadyout(hreadyout_v[1]), .hrdata(hrdata_v[1]),
        .hresp(hresp_v[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] data, input logic err,
                                input logic chk, input logic [31:0] rd);
        vec_t v;
        v.dut = d; v.write = w; v.addr = a; v.data = data;
        v.exp_err = err; v.chk_rd = chk; v.exp_rdata = rd;
        return v;
    endfunction

    // Reference: expectations derived from transfer order alone. A read sees
    // every earlier write; out-of-range indices error and never touch memory.
    function automatic void add_xfer(input int d, input logic w, input logic [31:0] a,
                                     input logic [31:0] data);
        vec_t v;
        v = mk(d, w, a, data, a >= DEPTH, 1'b0, 32'd0);
        v.chk_rd = !w && !v.exp_err;
        if (!v.exp_err) begin
            if (v.chk_rd) v.exp_rdata = model_mem[d][int'(a)];
            if (w) model_mem[d][int'(a)] = data;
        end
        xq.push_back(v);
    endfunction

    task automatic drive_idle(input int d);
        hsel_v[d] = 1'b0; htrans_v[d] = HTRANS_IDLE; haddr_v[d] = '0;
        hwrite_v[d] = 1'b0; hwdata_v[d] = '0; block_v[d] = 1'b0;
    endtask

    function automatic int exp_latency(input int d, input logic err);
        if (err) return 2;
        return (d == 0) ? 2 : 1;
    endfunction

    // Pipelined master: issues every queued transfer back to back. Called and
    // returns at a falling edge; outputs are sampled on falling edges.
    task automatic run_xfers(input int d);
        int   idx = 0;
        bit   dp_valid = 0;
        vec_t dp;
        int   cyc = 0;
        int   bad_resp = 0;
        int   budget = 4000;
        while ((idx < xq.size() || dp_valid) && budget > 0) begin
            budget--;
            hwdata_v[d] = (dp_valid && dp.write) ? dp.data : 32'hDEAD_BEEF;
            if (idx < xq.size()) begin
                hsel_v[d] = 1'b1; htrans_v[d] = HTRANS_NONSEQ;
                haddr_v[d] = xq[idx].addr; hwrite_v[d] = xq[idx].write;
            end else begin
                hsel_v[d] = 1'b0; htrans_v[d] = HTRANS_IDLE;
                haddr_v[d] = '0; hwrite_v[d] = 1'b0;
            end
            if (dp_valid) begin
                cyc++;
                if (hresp_v[d] !== dp.exp_err) bad_resp++;
                if (hreadyout_v[d]) begin
                    check($sformatf("d%0d a%0d w%0d hresp", d, dp.addr, dp.write),
                          hresp_v[d], dp.exp_err);
                    check($sformatf("d%0d a%0d w%0d resp_cycles", d, dp.addr, dp.write),
                          bad_resp, 0);
                    check($sformatf("d%0d a%0d w%0d latency", d, dp.addr, dp.write),
                          cyc, exp_latency(d, dp.exp_err));
                    if (dp.chk_rd)
                        check($sformatf("d%0d a%0d hrdata", d, dp.addr),
                              hrdata_v[d], dp.exp_rdata);
                    dp_valid = 0;
                end
            end
            if (hready_v[d] && idx < xq.size()) begin
                dp = xq[idx]; idx++; dp_valid = 1; cyc = 0; bad_resp = 0;
            end
            @(negedge hclk);
        end
        check($sformatf("d%0d transfers within budget", d), budget > 0, 1);
        drive_idle(d);
        @(negedge hclk);
        check($sformatf("d%0d idle hreadyout", d), hreadyout_v[d], 1);
        check($sformatf("d%0d idle hresp", d), hresp_v[d], 0);
        xq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            drive_idle(d);
            for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
        end
        hresetn = 1'b0;

        // Directed vectors: {dut, write, addr, data, exp_err, chk_rd, exp_rdata}
        tbl.push_back(mk(0, 1, 2,  6,           0, 0, 0));
        tbl.push_back(mk(0, 0, 2,  0,           0, 1, 6));
        tbl.push_back(mk(0, 0, 9,  0,           0, 1, 0));
        tbl.push_back(mk(0, 0, 20, 0,           1, 0, 0));
        tbl.push_back(mk(0, 1, 20, 32'hFFFF_FFFF, 1, 0, 0));
        tbl.push_back(mk(0, 0, 4,  0,           0, 1, 0));
        tbl.push_back(mk(0, 1, 15, 32'hA5,      0, 0, 0));
        tbl.push_back(mk(0, 0, 15, 0,           0, 1, 32'hA5));
        tbl.push_back(mk(1, 1, 7,  7,           0, 0, 0));
        tbl.push_back(mk(1, 0, 7,  0,           0, 1, 7));
        tbl.push_back(mk(1, 0, 16, 0,           1, 0, 0));
        tbl.push_back(mk(1, 1, 0,  1,           0, 0, 0));
        tbl.push_back(mk(1, 0, 0,  0,           0, 1, 1));

        // Reset state
        repeat (2) @(negedge hclk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d reset hreadyout", d), hreadyout_v[d], 1);
            check($sformatf("d%0d reset hresp", d), hresp_v[d], 0);
            check($sformatf("d%0d reset hrdata", d), hrdata_v[d], 0);
        end
        hresetn = 1'b1;
        @(negedge hclk);

        // Bus noise: unselected NONSEQ, then selected IDLE and BUSY
        hwdata_v[0] = 32'h99; haddr_v[0] = 9; hwrite_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hsel_v[0]   = (k != 0);
            htrans_v[0] = (k == 0) ? HTRANS_NONSEQ : (k == 1) ? HTRANS_IDLE : HTRANS_BUSY;
            @(negedge hclk);
            check($sformatf("noise%0d hreadyout", k), hreadyout_v[0], 1);
            check($sformatf("noise%0d hresp", k), hresp_v[0], 0);
        end
        drive_idle(0);

        // Table-driven directed transfers, one DUT at a time
        for (int d = 0; d < NDUT; d++) begin
            foreach (tbl[i]) begin
                if (tbl[i].dut == d) begin
                    xq.push_back(tbl[i]);
                    if (tbl[i].write && !tbl[i].exp_err)
                        model_mem[d][int'(tbl[i].addr)] = tbl[i].data;
                end
            end
            run_xfers(d);
        end

        // Error writes must leave every word intact
        for (int i = 0; i < DEPTH; i++) add_xfer(0, 1'b0, 32'(i), 32'd0);
        run_xfers(0);

        // hready gating: a presented NONSEQ is ignored while hready is low
        block_v[0] = 1'b1; hsel_v[0] = 1'b1; htrans_v[0] = HTRANS_NONSEQ;
        haddr_v[0] = 3; hwrite_v[0] = 1'b1; hwdata_v[0] = 32'h33;
        repeat (2) begin
            @(negedge hclk);
            check("gated hreadyout", hreadyout_v[0], 1);
        end
        block_v[0] = 1'b0;
        add_xfer(0, 1'b1, 3, 32'h33);
        add_xfer(0, 1'b0, 3, 32'd0);
        run_xfers(0);

        // Randomized traffic, including out-of-range indices
        for (int d = 0; d < NDUT; d++) begin
            for (int n = 0; n < 40; n++)
                add_xfer(d, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH + 3)), $urandom);
            for (int i = 0; i < DEPTH; i++) add_xfer(d, 1'b0, 32'(i), 32'd0);
            run_xfers(d);
        end

        // Reset in the wait state of a write to index 8
        hsel_v[0] = 1'b1; htrans_v[0] = HTRANS_NONSEQ; haddr_v[0] = 8;
        hwrite_v[0] = 1'b1; hwdata_v[0] = 8;
        @(negedge hclk);
        check("mid-write hreadyout", hreadyout_v[0], 0);
        #2 hresetn = 1'b0;
        #1;
        check("async reset hreadyout", hreadyout_v[0], 1);
        check("async reset hresp", hresp_v[0], 0);
        check("async reset hrdata", hrdata_v[0], 0);
        drive_idle(0);
        repeat (2) @(negedge hclk);
        hresetn = 1'b1;
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < DEPTH; i++) model_mem[d][i] = '0;
        add_xfer(0, 1'b0, 8, 32'd0);
        run_xfers(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
